countdown_preset_timer: RTL and testbench

Parametrised countdown timer with a mode-selected preset table, for the countdown clock. A MODE_W-bit switch code picks one of 2**MODE_W minute:second presets, which load into a minute/second down-counter. The counter is driven by an internal clock prescaler, supports start/pause/resume, and flags expiry. It sits between the switch inputs and the display driver, and extends the fixed two-switch mode decode to a configurable table with real timing behaviour.

---
 rtl/countdown_preset_timer.sv | 146 ++++++++++++++
 tb/tb_countdown_preset_timer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_preset_timer.sv
// Minute:second countdown timer loaded from a mode-selected preset table.
// A free-running prescaler in RUN produces the one-second decrement ticks.
module countdown_preset_timer #(
  parameter int MODE_W = 2,
  parameter int TICK_DIV = 50_000_000,
  parameter logic [12*(2**MODE_W)-1:0] PRESETS = {12'd2<<6, 12'd1<<6, 12'd30, 12'd5}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              load_i,
  input  logic              start_i,
  input  logic              pause_i,
  output logic [5:0]        minutes_o,
  output logic [5:0]        seconds_o,
  output logic              running_o,
  output logic              done_o,
  output logic              expired_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0] MAX_FIELD = 6'd59;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READY   = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSED  = 3'd3,
    S_EXPIRED = 3'd4
  } state_e;

  function automatic logic [5:0] clamp_field(input logic [5:0] f);
    clamp_field = (f > MAX_FIELD) ? MAX_FIELD : f;
  endfunction

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [5:0]    min_q, sec_q;
  logic          running_q, done_q, expired_q;

  logic [11:0]   preset_s;
  logic [5:0]    preset_min_d, preset_sec_d;
  logic [5:0]    min_dec_d, sec_dec_d;
  logic          tick_s, last_tick_s, count_zero_s;

  always_comb begin
    preset_s     = PRESETS[12*int'(mode_i) +: 12];
    preset_min_d = clamp_field(preset_s[11:6]);
    preset_sec_d = clamp_field(preset_s[5:0]);
  end

  always_comb begin
    tick_s       = (presc_q == TICK_LAST);
    count_zero_s = (min_q == 6'd0) && (sec_q == 6'd0);
    last_tick_s  = (min_q == 6'd0) && (sec_q == 6'd1);
    min_dec_d    = min_q;
    sec_dec_d    = sec_q;
    if (sec_q != 6'd0) begin
      sec_dec_d = sec_q - 6'd1;
    end else if (min_q != 6'd0) begin
      sec_dec_d = MAX_FIELD;
      min_dec_d = min_q - 6'd1;
    end else begin
      sec_dec_d = 6'd0;
      min_dec_d = 6'd0;
    end
  end

  // Control FSM; load dominates start, which dominates pause.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        state_q   <= S_READY;
        min_q     <= preset_min_d;
        sec_q     <= preset_sec_d;
        presc_q   <= '0;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state_q)
          S_READY, S_PAUSED: begin
            if (start_i) begin
              if (count_zero_s) begin
                state_q   <= S_EXPIRED;
                presc_q   <= '0;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
                running_q <= 1'b0;
              end else begin
                state_q   <= S_RUN;
                running_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (pause_i) begin
              state_q   <= S_PAUSED;
              running_q <= 1'b0;
            end else if (tick_s) begin
              presc_q <= '0;
              min_q   <= min_dec_d;
              sec_q   <= sec_dec_d;
              // The tick that lands on 0:00 expires on the same edge.
              if (last_tick_s) begin
                state_q   <= S_EXPIRED;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
                running_q <= 1'b0;
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          S_IDLE, S_EXPIRED: begin
            state_q <= state_q;
          end
          default: begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign minutes_o = min_q;
  assign seconds_o = sec_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign expired_o = expired_q;

endmodule

// File: tb/tb_countdown_preset_timer.sv
// Self-checking bench for countdown_preset_timer: a total-seconds reference
// model tracks the default-table instance; a second instance covers 0:00 and clamping.
module tb_countdown_preset_timer;
  localparam int TD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load, start, pause;
  logic [1:0] mode;
  logic [5:0] min1, sec1, min2, sec2;
  logic       run1, done1, exp1, run2, done2, exp2;

  countdown_preset_timer #(.MODE_W(2), .TICK_DIV(TD)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .load_i(load), .start_i(start),
    .pause_i(pause), .minutes_o(min1), .seconds_o(sec1), .running_o(run1),
    .done_o(done1), .expired_o(exp1));

  countdown_preset_timer #(.MODE_W(2), .TICK_DIV(TD),
    .PRESETS({12'hFFF, 12'h1FF, 12'd10, 12'd0})) dut2 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .load_i(load), .start_i(start),
    .pause_i(pause), .minutes_o(min2), .seconds_o(sec2), .running_o(run2),
    .done_o(done2), .expired_o(exp2));

  int checks = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 ready, 2 run, 3 paused, 4 expired.
  int m_st = 0, m_total = 0, m_phase = 0;
  bit m_done = 1'b0, m_exp = 1'b0;
  int pre_min[4] = '{0, 0, 1, 2};
  int pre_sec[4] = '{5, 30, 0, 0};

  function automatic int lim59(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic model_step(input bit r, input bit l, input bit s, input bit p, input int md);
    m_done = 1'b0;
    if (!r) begin
      m_st = 0; m_total = 0; m_phase = 0; m_exp = 1'b0;
    end else if (l) begin
      m_total = lim59(pre_min[md]) * 60 + lim59(pre_sec[md]);
      m_phase = 0; m_exp = 1'b0; m_st = 1;
    end else if ((m_st == 1 || m_st == 3) && s) begin
      if (m_total == 0) begin m_st = 4; m_done = 1'b1; m_exp = 1'b1; end
      else m_st = 2;
    end else if (m_st == 2 && p) begin
      m_st = 3;
    end else if (m_st == 2) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_total--;
        if (m_total == 0) begin m_st = 4; m_done = 1'b1; m_exp = 1'b1; end
      end
    end
  endtask

  function automatic logic [14:0] exp_vec();
    return {6'(m_total / 60), 6'(m_total % 60), 1'(m_st == 2), 1'(m_done), 1'(m_exp)};
  endfunction

  task automatic cycle(input bit r, input bit l, input bit s, input bit p, input int md);
    rst_n = r; load = l; start = s; pause = p; mode = 2'(md);
    @(posedge clk);
    model_step(r, l, s, p, md);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3);
    checks++;
    if ({min1, sec1, run1, done1, exp1} !== 15'd0) begin
      failures++; $display("FAIL reset_dut1 got=%h exp=%h", {min1, sec1, run1, done1, exp1}, 15'd0);
    end
    checks++;
    if ({min2, sec2, run2, done2, exp2} !== 15'd0) begin
      failures++; $display("FAIL reset_dut2 got=%h exp=%h", {min2, sec2, run2, done2, exp2}, 15'd0);
    end
  endtask

  task automatic test_basic_countdown();
    int done_at = -1;
    int pulses = 0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    checks++;
    if ({min1, sec1} !== {6'd0, 6'd5}) begin
      failures++; $display("FAIL load_0_05 got=%0d:%0d exp=0:5", min1, sec1);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      checks++;
      if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
        failures++; $display("FAIL basic cyc=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, exp1}, exp_vec());
      end
      if (done1 === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
    end
    checks++;
    if (done_at != 20 || pulses != 1) begin
      failures++; $display("FAIL done_latency got=%0d pulses=%0d exp=20 pulses=1", done_at, pulses);
    end
  endtask

  task automatic test_minute_borrow();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 2);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 2);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checks++;
      if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
        failures++; $display("FAIL borrow cyc=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, exp1}, exp_vec());
      end
      if (i == 4 || i == 8) begin
        checks++;
        if ({min1, sec1} !== {6'd0, (i == 4) ? 6'd59 : 6'd58}) begin
          failures++; $display("FAIL borrow_value cyc=%0d got=%0d:%0d exp=0:%0d", i, min1, sec1, (i == 4) ? 59 : 58);
        end
      end
    end
  endtask

  task automatic test_pause_resume();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, (i % 3) == 0, 2);
      checks++;
      if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
        failures++; $display("FAIL paused cyc=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, exp1}, exp_vec());
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checks++;
    if ({sec1, run1} !== {6'd30, 1'b1}) begin
      failures++; $display("FAIL resume_hold got=%0d run=%0b exp=30 run=1", sec1, run1);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checks++;
    if ({sec1, run1} !== {6'd29, 1'b1}) begin
      failures++; $display("FAIL resume_tick got=%0d run=%0b exp=29 run=1", sec1, run1);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checks++;
      if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
        failures++; $display("FAIL resumed cyc=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, exp1}, exp_vec());
      end
    end
  endtask

  task automatic test_load_during_run();
    bit reached = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 3);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 3);
    for (int i = 0; i < 400 && !reached; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      checks++;
      if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
        failures++; $display("FAIL run_to_117 cyc=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, exp1}, exp_vec());
      end
      if (m_total == 77) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      failures++; $display("FAIL reach_117_timeout got=%0d exp=77", m_total);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 3);
    checks++;
    if ({min1, sec1, run1, exp1} !== {6'd2, 6'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reload_run got=%0d:%0d run=%0b exp=2:0 run=0", min1, sec1, run1);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
      checks++;
      if ({min1, sec1, run1} !== {6'd2, 6'd0, 1'b0}) begin
        failures++; $display("FAIL reload_hold cyc=%0d got=%0d:%0d run=%0b exp=2:0 run=0", i, min1, sec1, run1);
      end
    end
  endtask

  task automatic test_zero_and_clamp();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    checks++;
    if ({min2, sec2, run2, done2, exp2} !== {6'd0, 6'd0, 1'b0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL zero_start got=%h exp=%h", {min2, sec2, run2, done2, exp2}, {6'd0, 6'd0, 3'b011});
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    checks++;
    if ({run2, done2, exp2} !== 3'b001) begin
      failures++; $display("FAIL zero_after got=%b exp=001", {run2, done2, exp2});
    end
    checks++;
    if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
      failures++; $display("FAIL zero_dut1 got=%h exp=%h", {min1, sec1, run1, done1, exp1}, exp_vec());
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 2);
    checks++;
    if ({min2, sec2, exp2} !== {6'd7, 6'd59, 1'b0}) begin
      failures++; $display("FAIL clamp_sec got=%0d:%0d exp=7:59", min2, sec2);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 3);
    checks++;
    if ({min2, sec2} !== {6'd59, 6'd59}) begin
      failures++; $display("FAIL clamp_both got=%0d:%0d exp=59:59", min2, sec2);
    end
  endtask

  task automatic test_reset_mid_run();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1);
    checks++;
    if ({min1, sec1, run1, done1, exp1} !== 15'd0) begin
      failures++; $display("FAIL reset_mid_run got=%h exp=0", {min1, sec1, run1, done1, exp1});
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1);
      checks++;
      if ({min1, sec1, run1} !== 13'd0) begin
        failures++; $display("FAIL idle_start cyc=%0d got=%h exp=0", i, {min1, sec1, run1});
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      checks++;
      if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
        failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, exp1}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(63) != 0, $urandom_range(15) == 0, $urandom_range(3) == 0,
            $urandom_range(7) == 0, $urandom_range(3));
      checks++;
      if ({min1, sec1, run1, done1, exp1} !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, {min1, sec1, run1, done1, exp1}, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; mode = 2'd0;
    test_reset();
    test_basic_countdown();
    test_minute_borrow();
    test_pause_resume();
    test_load_during_run();
    test_zero_and_clamp();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
